// File: rtl/coeff_loader.sv
// -----------------------------------------------------------------------------
// coeff_loader
//
// Writer side of the packed coefficient bus read by the filter's coefficient
// selector. Coefficients arrive one per transfer on a valid/ready stream and
// are packed into a shadow register. After the last tap is accepted, the whole
// shadow register is copied to o_coeffs in a single cycle. The filter
// therefore keeps the previous set for the whole reload and never sees a
// partial set.
//
// Optional feature (macro COEFF_LOADER_CHECKSUM_EN):
//   Adds o_checksum, which is the sum (mod 2^COEFF_BITS) of the committed set.
//
// Ports:
//   clk            in   single clock, all state on the rising edge
//   rst_n          in   asynchronous active-low reset
//   i_start        in   one-cycle pulse that begins or restarts a load
//   i_coeff_valid  in   i_coeff carries a coefficient
//   i_coeff        in   signed coefficient, presented in tap order 0,1,2,...
//   o_coeff_ready  out  the loader accepts a coefficient this cycle
//   o_coeffs       out  active packed set, tap k at [k*COEFF_BITS +: COEFF_BITS]
//   o_coeffs_valid out  high once at least one full set has been committed
//   o_commit       out  one-cycle pulse in the cycle o_coeffs takes the new set
//   o_busy         out  high in LOAD and COMMIT
//   o_load_count   out  number of taps accepted in the current load
//   dbg_state      out  current FSM state (0 IDLE, 1 LOAD, 2 COMMIT)
//   o_checksum     out  (only with COEFF_LOADER_CHECKSUM_EN) checksum of the set
//
// Handshake: a coefficient transfers on a rising edge where i_coeff_valid and
// o_coeff_ready are both high. o_coeff_ready depends only on the state and
// never on i_coeff_valid. The producer may hold i_coeff_valid low for any
// number of cycles.
// -----------------------------------------------------------------------------
module coeff_loader #(
  parameter int NUMBER_OF_TAPS = 64,
  parameter int COEFF_BITS     = 16,
  localparam int COUNTER_BITS  = $clog2(NUMBER_OF_TAPS)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_start,
  input  logic                                 i_coeff_valid,
  input  logic [COEFF_BITS-1:0]                i_coeff,
  output logic                                 o_coeff_ready,
  output logic [COEFF_BITS*NUMBER_OF_TAPS-1:0] o_coeffs,
  output logic                                 o_coeffs_valid,
  output logic                                 o_commit,
  output logic                                 o_busy,
  output logic [COUNTER_BITS-1:0]              o_load_count,
`ifdef COEFF_LOADER_CHECKSUM_EN
  output logic [COEFF_BITS-1:0]                o_checksum,
`endif
  output logic [1:0]                           dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // The load index wraps at NUMBER_OF_TAPS-1, not at the counter's natural
  // wrap point, so tap counts that are not a power of two also work.
  localparam logic [COUNTER_BITS-1:0] LAST_IDX = COUNTER_BITS'(NUMBER_OF_TAPS - 1);

  state_t                                 state;
  logic [COEFF_BITS*NUMBER_OF_TAPS-1:0]   shadow;
  logic [COUNTER_BITS-1:0]                load_count;
  logic [COEFF_BITS*NUMBER_OF_TAPS-1:0]   coeffs;
  logic                                   coeffs_valid;
  logic                                   commit_q;
  logic                                   busy_q;
`ifdef COEFF_LOADER_CHECKSUM_EN
  logic [COEFF_BITS-1:0]                  sum_acc;
  logic [COEFF_BITS-1:0]                  checksum_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      shadow       <= '0;
      load_count   <= '0;
      coeffs       <= '0;
      coeffs_valid <= 1'b0;
      commit_q     <= 1'b0;
      busy_q       <= 1'b0;
`ifdef COEFF_LOADER_CHECKSUM_EN
      sum_acc      <= '0;
      checksum_q   <= '0;
`endif
    end else begin
      commit_q <= 1'b0;
      case (state)
        IDLE: begin
          // Coefficients presented in IDLE are ignored.
          if (i_start) begin
            state      <= LOAD;
            load_count <= '0;
            busy_q     <= 1'b1;
`ifdef COEFF_LOADER_CHECKSUM_EN
            sum_acc    <= '0;
`endif
          end
        end

        LOAD: begin
          if (i_start) begin
            // A restart takes priority over a coincident transfer. The old
            // shadow content is left in place because every slice is written
            // again before the next commit.
            load_count <= '0;
`ifdef COEFF_LOADER_CHECKSUM_EN
            sum_acc    <= '0;
`endif
          end else if (i_coeff_valid) begin
            shadow[int'(load_count)*COEFF_BITS +: COEFF_BITS] <= i_coeff;
`ifdef COEFF_LOADER_CHECKSUM_EN
            sum_acc <= sum_acc + i_coeff;
`endif
            if (load_count == LAST_IDX) begin
              load_count <= '0;
              state      <= COMMIT;
              // Registered so that the pulse lines up with the COMMIT cycle.
              commit_q   <= 1'b1;
            end else begin
              load_count <= load_count + 1'b1;
            end
          end
        end

        COMMIT: begin
          // The whole set is copied in one cycle. i_start is ignored here.
          coeffs       <= shadow;
          coeffs_valid <= 1'b1;
          state        <= IDLE;
          busy_q       <= 1'b0;
`ifdef COEFF_LOADER_CHECKSUM_EN
          checksum_q   <= sum_acc;
`endif
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_coeff_ready  = (state == LOAD);
  assign o_coeffs       = coeffs;
  assign o_coeffs_valid = coeffs_valid;
  assign o_commit       = commit_q;
  assign o_busy         = busy_q;
  assign o_load_count   = load_count;
  assign dbg_state      = state;
`ifdef COEFF_LOADER_CHECKSUM_EN
  assign o_checksum     = checksum_q;
`endif

endmodule

// File: doc/coeff_loader.md
Name: coeff_loader

Overview:
- Writer side of the packed coefficient bus used by the filter's coefficient selector.
- Accepts coefficients one per transfer over a valid/ready stream and packs them into a shadow register.
- After the last tap is received, commits the shadow register atomically to the active flat vector `o_coeffs`.
- Double-buffered: the filter keeps using the old set during a reload, with no glitch or partial set.

Parameters:
- `NUMBER_OF_TAPS`, 64: number of coefficients in the set.
- `COEFF_BITS`, 16: width of one signed coefficient.
- `COUNTER_BITS`, $clog2(NUMBER_OF_TAPS): width of the load index (localparam).

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `i_start`  in  1  one-cycle pulse; begins (or restarts) a load.
- `i_coeff_valid`  in  1  coefficient on `i_coeff` is valid.
- `i_coeff`  in  COEFF_BITS  signed coefficient; tap order 0,1,2,...
- `o_coeff_ready`  out  1  loader accepts a coefficient this cycle.
- `o_coeffs`  out  COEFF_BITS*NUMBER_OF_TAPS  active packed set; tap k at [k*COEFF_BITS +: COEFF_BITS].
- `o_coeffs_valid`  out  1  high once at least one full set has been committed.
- `o_commit`  out  1  one-cycle pulse in the cycle `o_coeffs` takes the new set.
- `o_busy`  out  1  high in LOAD and COMMIT.
- `o_load_count`  out  COUNTER_BITS  number of taps accepted in the current load.

Behaviour:
- Reset (async, `rst_n`=0):
  - State goes to IDLE.
  - `o_coeffs`, shadow register, `o_load_count`: 0.
  - `o_coeffs_valid`, `o_commit`, `o_busy`, `o_coeff_ready`: 0.
- Transfer rule: a coefficient is accepted on a rising edge where `i_coeff_valid` && `o_coeff_ready`.
- `o_coeff_ready` = (state==LOAD), combinational from state only, with no dependence on `i_coeff_valid`.
- IDLE:
  - `i_start`=1 → LOAD; `o_load_count` cleared to 0.
  - `i_coeff_valid` is ignored in IDLE, and no coefficient is captured.
- LOAD:
  - On each accepted transfer, the shadow slice at index `o_load_count` ← `i_coeff`, then `o_load_count` increments.
  - The accept with `o_load_count`==NUMBER_OF_TAPS-1 moves the state to COMMIT.
  - `o_load_count` wraps to 0 on that accept, with no overflow into an extra bit.
  - `i_coeff_valid` low holds state; stalls of any length are allowed.
- COMMIT (exactly 1 cycle, `o_coeff_ready`=0):
  - `o_coeffs` ← shadow, in a full-width single-cycle copy.
  - `o_commit`=1 and `o_coeffs_valid` ← 1 (sticky until reset).
  - Next state is IDLE.
- Latency: the last accept is at edge N, `o_coeffs` updates at edge N+1, and `o_commit` is high between edges N and N+1, registered.
- Restart: `i_start` during LOAD discards the partial shadow content logically. `o_load_count` goes to 0, the state stays LOAD, and any transfer in that same cycle is NOT captured (start wins).
- `i_start` during COMMIT is ignored; the commit completes.
- Partial load never disturbs `o_coeffs`. Stale shadow slices are overwritten before the next commit because every index is written once per complete load.
- NUMBER_OF_TAPS must be ≥2. Non-power-of-two tap counts are supported, with the wrap taken at NUMBER_OF_TAPS-1, not at 2^COUNTER_BITS-1.
- Reset mid-LOAD: all state is cleared immediately, including `o_coeffs` and `o_coeffs_valid`.

Optional Feature:
- Macro: `COEFF_LOADER_CHECKSUM_EN`.
- Defined:
  - Extra output `o_checksum` [COEFF_BITS-1:0], reset to 0.
  - A running sum (mod 2^COEFF_BITS) of accepted coefficients is cleared on `i_start`.
  - The sum is copied to `o_checksum` in the COMMIT cycle, alongside `o_coeffs`.
- Undefined: the port and the accumulator are absent, and all other behaviour is identical.

Test Plan:
- Reset then idle: hold `rst_n`=0 for 3 cycles, release → `o_coeffs`=0, `o_coeffs_valid`=0, `o_coeff_ready`=0. Driving `i_coeff_valid`=1 with 16'h1234 in IDLE leaves `o_load_count`=0.
- Full load, no stalls: `i_start`, then 64 back-to-back taps with values 16'h0000+k → `o_commit` pulses exactly once, one cycle after the 64th accept.
  - Slice k of `o_coeffs` equals k.
  - Feeding `o_coeffs` into the coefficient selector with count 0..63 reads back 0..63.
- Stalled load with double buffering: the active set is all 16'h1111. Load all 16'hEEEE with `i_coeff_valid` toggling every other cycle → `o_coeffs` stays all 16'h1111 until the commit edge, then becomes all 16'hEEEE in one cycle.
- Restart mid-load: after 10 taps of 16'hAAAA, pulse `i_start` coincident with `i_coeff_valid`=1 → `o_load_count`=0 and the coincident tap is dropped.
  - 64 further taps of 16'h5555 commit all 16'h5555.
- Async reset mid-LOAD: assert `rst_n`=0 between edges after 30 taps → outputs clear without waiting for a clock edge, and the state is IDLE after release.
- Checksum (macro on): taps 16'h8000 ×2, the rest 0 → `o_checksum`=16'h0000 (wrap). Taps with values 1..64 → `o_checksum`=16'h0820.
